// File: rtl/irq_pkg.sv
// Shared types and register map for the interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [2:0] REG_PEND = 3'd0;
    localparam logic [2:0] REG_MASK = 3'd1;
    localparam logic [2:0] REG_MODE = 3'd2;
    localparam logic [2:0] REG_ISR  = 3'd3;

    localparam int ISR_VLD_BIT = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set index wins, any_o flags a non-empty input.
module irq_prio_enc #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic         any_o,
    output logic [W-1:0] id_o
);

    assign any_o = |req_i;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        id_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) id_o = W'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: pending/mask/mode registers, prioritised CPU request, ISR tracking.
// Build option IRQ_SYNC_EN adds a 2-flop synchroniser on every source line.
module irq_ctrl #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:2]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] src,
    input  logic             int_ack,
    output logic [N_SRC-1:0] HWInt,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id
);
    import irq_pkg::*;

    irq_state_t       state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mode_q, prev_q, hwint_q;
    logic             isr_vld_q, isr_vld_d;
    logic [ID_W-1:0]  isr_id_q, isr_id_d;

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] ack_vec, clr_vec;
    logic             any_req;
    logic [ID_W-1:0]  enc_id;
    logic [2:0]       off;
    logic             wr_pend, wr_mask, wr_mode, eoi, ack_take;
    logic             unused_ok;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src;
`endif

    assign off       = Addr[4:2];
    assign wr_pend   = WE && (off == REG_PEND);
    assign wr_mask   = WE && (off == REG_MASK);
    assign wr_mode   = WE && (off == REG_MODE);
    assign eoi       = WE && (off == REG_ISR);
    assign unused_ok = ^{Addr[31:5], Din[31:N_SRC]};

    assign active = pend_q & mask_q;

    irq_prio_enc #(.N(N_SRC), .W(ID_W)) u_enc (
        .req_i (active),
        .any_o (any_req),
        .id_o  (enc_id)
    );

    assign ack_take = (state_q == REQ) && int_ack;
    assign ack_vec  = ack_take ? (N_SRC'(1) << enc_id) : '0;
    assign clr_vec  = (wr_pend ? Din[N_SRC-1:0] : '0) | ack_vec;

    // Edge sources: a fresh rising edge overrides any clear in the same cycle.
    // Level sources simply mirror the line, so W1C cannot stick while it is high.
    assign pend_d = (mode_q & ((src_s & ~prev_q) | (pend_q & ~clr_vec)))
                  | (~mode_q & src_s);

    always_comb begin
        state_d   = state_q;
        isr_vld_d = isr_vld_q;
        isr_id_d  = isr_id_q;
        int_req   = 1'b0;
        int_id    = '0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = REQ;
            end
            REQ: begin
                int_req = 1'b1;
                int_id  = enc_id;
                if (int_ack) begin
                    state_d   = SERVICE;
                    isr_vld_d = 1'b1;
                    isr_id_d  = enc_id;
                end else if (!any_req) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d   = IDLE;
                    isr_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            mask_q    <= '0;
            mode_q    <= '0;
            prev_q    <= '0;
            hwint_q   <= '0;
            isr_vld_q <= 1'b0;
            isr_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            prev_q    <= src_s;
            hwint_q   <= active;
            isr_vld_q <= isr_vld_d;
            isr_id_q  <= isr_id_d;
            if (wr_mask) mask_q <= Din[N_SRC-1:0];
            if (wr_mode) mode_q <= Din[N_SRC-1:0];
        end
    end

    assign HWInt = hwint_q;

    always_comb begin
        Dout = '0;
        case (off)
            REG_PEND: Dout = 32'(pend_q);
            REG_MASK: Dout = 32'(mask_q);
            REG_MODE: Dout = 32'(mode_q);
            REG_ISR: begin
                Dout[ISR_VLD_BIT] = isr_vld_q;
                Dout[ID_W-1:0]    = isr_id_q;
            end
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_irq_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_SVC  = 2;
    localparam int SEL_DOUT = 0, SEL_HW = 1, SEL_REQ = 2, SEL_ID = 3;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset_n;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  src;
    logic        int_ack;
    logic [5:0]  HWInt;
    logic        int_req;
    logic [2:0]  int_id;

    irq_ctrl dut (
        .clk(clk), .reset_n(reset_n), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout),
        .src(src), .int_ack(int_ack), .HWInt(HWInt), .int_req(int_req), .int_id(int_id)
    );

    always #5 if (clk_en) clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edges = 0;

    typedef struct {
        int          tag;
        int          sel;
        logic [31:0] exp;
        string       nm;
    } exp_t;
    exp_t sb[$];

    // Behavioural model state (values as seen after the most recent edge).
    bit [5:0] m_pend, m_mask, m_mode, m_prev, m_hw, m_s1, m_s2;
    int       m_st;
    bit       m_isrv;
    int       m_isrid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_out(input int sel);
        case (sel)
            SEL_DOUT: return Dout;
            SEL_HW:   return 32'(HWInt);
            SEL_REQ:  return 32'(int_req);
            default:  return 32'(int_id);
        endcase
    endfunction

    // Monitor: compares every expectation whose target edge has just passed.
    initial forever begin
        @(posedge clk);
        edges++;
        #1;
        while (sb.size() > 0 && sb[0].tag <= edges) begin
            exp_t e;
            e = sb.pop_front();
            if (e.tag < edges) chk({"stale_", e.nm}, 32'(e.tag), 32'(edges));
            else chk(e.nm, dut_out(e.sel), e.exp);
        end
    end

    function automatic int prio(input bit [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] model_rd(input int off);
        case (off)
            0: return 32'(m_pend);
            1: return 32'(m_mask);
            2: return 32'(m_mode);
            3: return {m_isrv, 28'd0, 3'(m_isrid)};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0; m_hw = 0;
        m_s1 = 0; m_s2 = 0; m_st = S_IDLE; m_isrv = 0; m_isrid = 0;
    endtask

    // One clock edge of the model, applying the spec rules to pre-edge state.
    task automatic model_edge(input int off, input bit we, input logic [31:0] din,
                              input bit [5:0] s, input bit ack);
        bit [5:0] se, act, np, nmask, nmode;
        int       id, nst;
        bit       w1c;
        se = s;
`ifdef IRQ_SYNC_EN
        se = m_s2;
        m_s2 = m_s1;
        m_s1 = s;
`endif
        act = m_pend & m_mask;
        id = prio(act);
        for (int i = 0; i < 6; i++) begin
            if (m_mode[i]) begin
                w1c = we && off == 0 && din[i];
                np[i] = (se[i] && !m_prev[i])
                      || (m_pend[i] && !w1c && !(m_st == S_REQ && ack && id == i));
            end else begin
                np[i] = se[i];
            end
        end
        nmask = (we && off == 1) ? din[5:0] : m_mask;
        nmode = (we && off == 2) ? din[5:0] : m_mode;
        nst = m_st;
        if (m_st == S_IDLE && act != 0) nst = S_REQ;
        else if (m_st == S_REQ && ack) begin
            nst = S_SVC; m_isrv = 1; m_isrid = id;
        end else if (m_st == S_REQ && act == 0) nst = S_IDLE;
        else if (m_st == S_SVC && we && off == 3) begin
            nst = S_IDLE; m_isrv = 0;
        end
        m_hw = act;
        m_prev = se;
        m_pend = np;
        m_mask = nmask;
        m_mode = nmode;
        m_st = nst;
    endtask

    task automatic expect_next(input int sel, input logic [31:0] v, input string nm);
        sb.push_back('{edges + 1, sel, v, nm});
    endtask

    // Called just after a falling edge; drives one cycle and returns at the next falling edge.
    task automatic step(input int off, input bit we, input logic [31:0] din,
                        input bit [5:0] s, input bit ack);
        logic [31:2] a;
        a = 30'($urandom);
        a[4:2] = 3'(off);
        Addr = a; WE = we; Din = din; src = s; int_ack = ack;
        model_edge(off, we, din, s, ack);
        expect_next(SEL_DOUT, model_rd(off), "dout");
        expect_next(SEL_HW, 32'(m_hw), "hwint");
        expect_next(SEL_REQ, 32'(m_st == S_REQ), "int_req");
        if (m_st == S_REQ) expect_next(SEL_ID, 32'(prio(m_pend & m_mask)), "int_id");
        @(negedge clk);
    endtask

    task automatic idle(input int n, input int off, input bit [5:0] s);
        for (int i = 0; i < n; i++) step(off, 0, 0, s, 0);
    endtask

    task automatic ack_wait(input bit [5:0] s, input int off);
        int k = 0;
        while (m_st != S_REQ && k < 10) begin
            step(off, 0, 0, s, 0);
            k++;
        end
        chk("ack_wait_state", 32'(m_st), 32'(S_REQ));
        step(off, 0, 0, s, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int       off;
        bit       we;
        bit       ack;
        bit [5:0] cur;
        logic [31:0] din;

        // Reset with the clock stopped.
        reset_n = 1'b0; WE = 0; Din = 0; src = 0; int_ack = 0; Addr = '0;
        model_reset();
        #3;
        chk("rst_int_req", 32'(int_req), 32'd0);
        chk("rst_hwint", 32'(HWInt), 32'd0);
        for (int r = 0; r < 4; r++) begin
            Addr[4:2] = 3'(r);
            #1;
            chk("rst_reg", Dout, 32'd0);
        end
        reset_n = 1'b1;
        #1;
        clk_en = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) step(r, 0, 0, 6'h00, 0);

        // Edge-triggered source 0.
        step(1, 1, 32'h3F, 6'h00, 0);
        step(2, 1, 32'h01, 6'h00, 0);
`ifndef IRQ_SYNC_EN
        expect_next(SEL_DOUT, 32'h1, "edge_pend");
`endif
        step(0, 0, 0, 6'h01, 0);
`ifndef IRQ_SYNC_EN
        expect_next(SEL_REQ, 32'h1, "edge_req");
        expect_next(SEL_ID, 32'h0, "edge_id");
`endif
        step(0, 0, 0, 6'h00, 0);
        ack_wait(6'h00, 3);
        step(3, 1, 0, 6'h00, 0);

        // Level priority and handshake.
        step(2, 1, 32'h00, 6'h00, 0);
        step(3, 0, 0, 6'h14, 0);
`ifndef IRQ_SYNC_EN
        expect_next(SEL_ID, 32'h2, "lvl_id2");
`endif
        step(3, 0, 0, 6'h14, 0);
        idle(2, 3, 6'h14);
`ifndef IRQ_SYNC_EN
        expect_next(SEL_DOUT, 32'h8000_0002, "lvl_isr");
        expect_next(SEL_REQ, 32'h0, "lvl_svc_req");
`endif
        step(3, 0, 0, 6'h14, 1);
        step(3, 1, 0, 6'h14, 0);
        idle(2, 3, 6'h14);
        step(3, 0, 0, 6'h10, 0);
        ack_wait(6'h10, 3);
        step(3, 1, 0, 6'h10, 0);
        idle(3, 3, 6'h10);
        ack_wait(6'h00, 3);
        step(3, 1, 0, 6'h00, 0);
        idle(2, 0, 6'h00);

        // Set beats clear on edge-mode source 1.
        step(2, 1, 32'h02, 6'h00, 0);
        idle(2, 0, 6'h00);
`ifndef IRQ_SYNC_EN
        expect_next(SEL_DOUT, 32'h2, "set_beats_clr");
`endif
        step(0, 1, 32'h02, 6'h02, 0);
        idle(2, 0, 6'h02);
        ack_wait(6'h00, 3);
        step(3, 1, 0, 6'h00, 0);

        // Withdrawn request.
        step(2, 1, 32'h00, 6'h01, 0);
        idle(3, 3, 6'h01);
        step(1, 1, 32'h00, 6'h01, 0);
`ifndef IRQ_SYNC_EN
        expect_next(SEL_REQ, 32'h0, "withdraw_req");
`endif
        step(3, 0, 0, 6'h01, 0);
        idle(2, 3, 6'h00);

        // Reset in the middle of SERVICE.
        step(1, 1, 32'h3F, 6'h08, 0);
        ack_wait(6'h08, 3);
        #1;
        reset_n = 1'b0;
        src = 6'h00;
        Addr[4:2] = 3'd3;
        #1;
        chk("midrst_int_req", 32'(int_req), 32'd0);
        chk("midrst_hwint", 32'(HWInt), 32'd0);
        chk("midrst_isr", Dout, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(3, 0, 0, 6'h00, 0);
        expect_next(SEL_DOUT, 32'h0, "midrst_pend");
        step(0, 0, 0, 6'h00, 0);

        // Random traffic.
        cur = 6'h00;
        for (int n = 0; n < 2500; n++) begin
            off = $urandom_range(0, 7);
            we  = ($urandom_range(0, 3) == 0);
            din = $urandom;
            if (m_st == S_SVC && $urandom_range(0, 5) == 0) begin
                off = 3; we = 1;
            end
            if ($urandom_range(0, 3) == 0) cur = cur ^ 6'($urandom);
            ack = (m_st == S_REQ) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            step(off, we, din, cur, ack);
        end
        idle(3, 0, 6'h00);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
